// File: rtl/parking_pkg.sv
// parking_pkg -- shared definitions for the parking controller slice.
//   state_t       : controller FSM states (IDLE / ENTER / LEAVE)
//   DEF_CAPACITY  : default number of parking spaces
//   DEF_GATE_CYC  : default gate-open time in cycles per accepted car
//   SEG_TABLE     : 16-entry active-low 7-segment table, bit order {g,f,e,d,c,b,a}
//   seg_pattern() : table lookup helper
package parking_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTER = 2'd1,
    LEAVE = 2'd2
  } state_t;

  localparam int DEF_CAPACITY = 8;
  localparam int DEF_GATE_CYC = 50;

  // Entry n sits at bits [7n+6:7n]; hex glyphs 0..F, active-low.
  localparam logic [15:0][6:0] SEG_TABLE = '{
    7'h0E, 7'h06, 7'h21, 7'h46,  // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,  // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,  // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40   // 3 2 1 0
  };

  function automatic logic [6:0] seg_pattern(input logic [3:0] val);
    return SEG_TABLE[val];
  endfunction

endpackage

// File: rtl/parking_ctrl_if.sv
// parking_ctrl_if -- sensor/status bundle of the parking controller.
//   Entry_P, Exit_P : single-cycle debounced sensor pulses (into controller)
//   Occ             : cars currently parked (CNT_W bits)
//   Full, Empty     : occupancy flags
//   Gate_In/Gate_Out: gate open indications
//   Reject          : one-cycle refusal pulse
//   Seg             : active-low 7-segment free-space display
// Modports: master = sensor/host side, slave = controller.
interface parking_ctrl_if #(
  parameter int CNT_W = 4
) ();

  logic             Entry_P;
  logic             Exit_P;
  logic [CNT_W-1:0] Occ;
  logic             Full;
  logic             Empty;
  logic             Gate_In;
  logic             Gate_Out;
  logic             Reject;
  logic [6:0]       Seg;

  modport master (
    output Entry_P, Exit_P,
    input  Occ, Full, Empty, Gate_In, Gate_Out, Reject, Seg
  );

  modport slave (
    input  Entry_P, Exit_P,
    output Occ, Full, Empty, Gate_In, Gate_Out, Reject, Seg
  );

endinterface

// File: rtl/parking_ctrl_seg7_dec.sv
// seg7_dec -- combinational hex to active-low 7-segment decoder.
//   val : 4-bit value 0..F
//   seg : active-low segment pattern {g,f,e,d,c,b,a}
module seg7_dec
  import parking_pkg::*;
(
  input  logic [3:0] val,
  output logic [6:0] seg
);

  always_comb begin
    seg = seg_pattern(val);
  end

endmodule

// File: rtl/parking_ctrl.sv
// parking_ctrl -- parking lot entry/exit gate controller.
//   CLK : system clock, rising edge
//   RST : asynchronous active-high reset
//   bus : parking_ctrl_if.slave (sensor pulses in; Occ, Full, Empty,
//         Gate_In, Gate_Out, Reject, Seg out)
// Each accepted car opens its gate for GATE_CYC cycles; pulses arriving
// while a gate is open are remembered in one pending bit per direction.
// Exit requests win over entry requests.
// Optional macro PARKING_DISPLAY_EN: registered 7-segment display of free
// spaces; without it Seg is tied to 7'h7F (all segments off).
module parking_ctrl
  import parking_pkg::*;
#(
  parameter int CAPACITY = DEF_CAPACITY,
  parameter int GATE_CYC = DEF_GATE_CYC,
  parameter int CNT_W    = 4
) (
  input  logic          CLK,
  input  logic          RST,
  parking_ctrl_if.slave bus
);

  localparam int               TIM_W  = $clog2(GATE_CYC);
  localparam logic [CNT_W-1:0] CAP    = CNT_W'(CAPACITY);
  localparam logic [TIM_W-1:0] RELOAD = TIM_W'(GATE_CYC - 1);

  state_t           state;
  logic [CNT_W-1:0] occ;
  logic [TIM_W-1:0] timer;
  logic             pend_in, pend_out;
  logic             full_q, empty_q, gin_q, gout_q, rej_q;

  logic req_in, req_out;
  assign req_in  = bus.Entry_P | pend_in;
  assign req_out = bus.Exit_P  | pend_out;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      occ      <= '0;
      timer    <= '0;
      pend_in  <= 1'b0;
      pend_out <= 1'b0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      gin_q    <= 1'b0;
      gout_q   <= 1'b0;
      rej_q    <= 1'b0;
    end else begin
      rej_q <= 1'b0;
      // Unserviced pulses accumulate; the branches below clear a bit when
      // its request is serviced (accepted or refused).
      pend_in  <= pend_in  | bus.Entry_P;
      pend_out <= pend_out | bus.Exit_P;
      case (state)
        IDLE: begin
          if (req_out) begin
            pend_out <= 1'b0;
            if (occ == '0) begin
              rej_q <= 1'b1;
            end else begin
              state   <= LEAVE;
              timer   <= RELOAD;
              occ     <= occ - CNT_W'(1);
              gout_q  <= 1'b1;
              full_q  <= 1'b0;
              empty_q <= (occ == CNT_W'(1));
            end
          end else if (req_in) begin
            pend_in <= 1'b0;
            if (occ == CAP) begin
              rej_q <= 1'b1;
            end else begin
              state   <= ENTER;
              timer   <= RELOAD;
              occ     <= occ + CNT_W'(1);
              gin_q   <= 1'b1;
              empty_q <= 1'b0;
              full_q  <= (occ == CAP - CNT_W'(1));
            end
          end
        end
        ENTER, LEAVE: begin
          if (timer == '0) begin
            state  <= IDLE;
            gin_q  <= 1'b0;
            gout_q <= 1'b0;
          end else begin
            timer <= timer - TIM_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Occ      = occ;
  assign bus.Full     = full_q;
  assign bus.Empty    = empty_q;
  assign bus.Gate_In  = gin_q;
  assign bus.Gate_Out = gout_q;
  assign bus.Reject   = rej_q;

`ifdef PARKING_DISPLAY_EN
  logic [CNT_W-1:0] free_cnt;
  logic [6:0]       seg_d, seg_q;

  assign free_cnt = CAP - occ;

  seg7_dec u_seg7_dec (
    .val (4'(free_cnt)),
    .seg (seg_d)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) seg_q <= seg_pattern(4'(CAPACITY));
    else     seg_q <= seg_d;
  end

  assign bus.Seg = seg_q;
`else
  assign bus.Seg = 7'h7F;
`endif

endmodule

// File: tb/tb_parking_ctrl.sv
// tb_parking_ctrl -- directed bench for parking_ctrl (CAPACITY=3, GATE_CYC=4).
// Build with or without +define+PARKING_DISPLAY_EN.
module tb_parking_ctrl;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  always #5 CLK = ~CLK;

  parking_ctrl_if #(.CNT_W(4)) bus ();

  parking_ctrl #(
    .CAPACITY (3),
    .GATE_CYC (4),
    .CNT_W    (4)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       en;
    logic       ex;
    logic [3:0] occ;
    logic       full;
    logic       empty;
    logic       gin;
    logic       gout;
    logic       rej;
  } vec_t;

  vec_t vecs[25];

  function automatic vec_t mk(input logic en, input logic ex, input int occ,
                              input logic full, input logic empty,
                              input logic gin, input logic gout, input logic rej);
    vec_t v;
    v.en = en; v.ex = ex; v.occ = 4'(occ); v.full = full; v.empty = empty;
    v.gin = gin; v.gout = gout; v.rej = rej;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance past the next rising edge; inputs driven afterwards apply to
  // the following edge and outputs are stable for sampling.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_state(input string tag, input int occ, input logic full,
                           input logic empty, input logic gin, input logic gout,
                           input logic rej);
    check({tag, ".Occ"},      int'(bus.Occ),      occ);
    check({tag, ".Full"},     int'(bus.Full),     int'(full));
    check({tag, ".Empty"},    int'(bus.Empty),    int'(empty));
    check({tag, ".Gate_In"},  int'(bus.Gate_In),  int'(gin));
    check({tag, ".Gate_Out"}, int'(bus.Gate_Out), int'(gout));
    check({tag, ".Reject"},   int'(bus.Reject),   int'(rej));
    check({tag, ".gates_excl"}, int'(bus.Gate_In & bus.Gate_Out), 0);
  endtask

  initial begin
    //                en  ex  occ full empty gin gout rej
    vecs[0]  = mk(0, 0, 0, 0, 1, 0, 0, 0);  // idle after reset
    vecs[1]  = mk(0, 1, 0, 0, 1, 0, 0, 1);  // exit while empty: refused
    vecs[2]  = mk(0, 0, 0, 0, 1, 0, 0, 0);  // reject lasts one cycle, not pending
    vecs[3]  = mk(1, 0, 1, 0, 0, 1, 0, 0);  // entry accepted, edge k
    vecs[4]  = mk(0, 0, 1, 0, 0, 1, 0, 0);  // k+1
    vecs[5]  = mk(0, 0, 1, 0, 0, 1, 0, 0);  // k+2
    vecs[6]  = mk(1, 0, 1, 0, 0, 1, 0, 0);  // k+3, entry pulse goes pending
    vecs[7]  = mk(0, 0, 1, 0, 0, 0, 0, 0);  // k+4 gate closes
    vecs[8]  = mk(0, 0, 2, 0, 0, 1, 0, 0);  // pending entry serviced
    vecs[9]  = mk(0, 0, 2, 0, 0, 1, 0, 0);
    vecs[10] = mk(0, 0, 2, 0, 0, 1, 0, 0);
    vecs[11] = mk(0, 0, 2, 0, 0, 1, 0, 0);
    vecs[12] = mk(0, 0, 2, 0, 0, 0, 0, 0);
    vecs[13] = mk(1, 0, 3, 1, 0, 1, 0, 0);  // third car: Full
    vecs[14] = mk(0, 0, 3, 1, 0, 1, 0, 0);
    vecs[15] = mk(0, 0, 3, 1, 0, 1, 0, 0);
    vecs[16] = mk(0, 0, 3, 1, 0, 1, 0, 0);
    vecs[17] = mk(0, 0, 3, 1, 0, 0, 0, 0);
    vecs[18] = mk(1, 0, 3, 1, 0, 0, 0, 1);  // fourth car refused
    vecs[19] = mk(0, 0, 3, 1, 0, 0, 0, 0);
    vecs[20] = mk(0, 1, 2, 0, 0, 0, 1, 0);  // exit accepted
    vecs[21] = mk(0, 0, 2, 0, 0, 0, 1, 0);
    vecs[22] = mk(0, 0, 2, 0, 0, 0, 1, 0);
    vecs[23] = mk(0, 0, 2, 0, 0, 0, 1, 0);
    vecs[24] = mk(0, 0, 2, 0, 0, 0, 0, 0);

    bus.Entry_P = 1'b0;
    bus.Exit_P  = 1'b0;

    // Reset held across edges
    tick();
    chk_state("reset", 0, 0, 1, 0, 0, 0);
    tick();
    RST = 1'b0;

    foreach (vecs[i]) begin
      bus.Entry_P = vecs[i].en;
      bus.Exit_P  = vecs[i].ex;
      tick();
      bus.Entry_P = 1'b0;
      bus.Exit_P  = 1'b0;
      chk_state($sformatf("vec%0d", i), int'(vecs[i].occ), vecs[i].full,
                vecs[i].empty, vecs[i].gin, vecs[i].gout, vecs[i].rej);
`ifndef PARKING_DISPLAY_EN
      check($sformatf("vec%0d.Seg", i), int'(bus.Seg), 'h7F);
`endif
    end

    // Simultaneous entry and exit with Occ=2: exit first, entry afterwards
    bus.Entry_P = 1'b1;
    bus.Exit_P  = 1'b1;
    tick();
    bus.Entry_P = 1'b0;
    bus.Exit_P  = 1'b0;
    chk_state("both.e0", 1, 0, 0, 0, 1, 0);
    for (int c = 1; c <= 3; c++) begin
      tick();
      chk_state($sformatf("both.e%0d", c), 1, 0, 0, 0, 1, 0);
    end
    tick();
    chk_state("both.e4", 1, 0, 0, 0, 0, 0);
    tick();
    chk_state("both.e5", 2, 0, 0, 1, 0, 0);

    // Reset two cycles into ENTER with an entry pending
    tick();
    bus.Entry_P = 1'b1;
    tick();
    bus.Entry_P = 1'b0;
    chk_state("rst.pre", 2, 0, 0, 1, 0, 0);
    #2 RST = 1'b1;
    #2;
    chk_state("rst.async", 0, 0, 1, 0, 0, 0);
    #1 RST = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      chk_state($sformatf("rst.idle%0d", c), 0, 0, 1, 0, 0, 0);
    end

    // Fresh entry from IDLE; display follows Occ one cycle later
    bus.Entry_P = 1'b1;
    tick();
    bus.Entry_P = 1'b0;
    chk_state("post.e0", 1, 0, 0, 1, 0, 0);
`ifdef PARKING_DISPLAY_EN
    check("seg.lag", int'(bus.Seg), 'h30);
    tick();
    check("seg.free2", int'(bus.Seg), 'h24);
`else
    check("seg.off0", int'(bus.Seg), 'h7F);
    tick();
    check("seg.off1", int'(bus.Seg), 'h7F);
`endif
    check("post.e1.Occ", int'(bus.Occ), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
